// File: rtl/alarm_ring_if.sv
// Bundle of signals between the clock core and the alarm ring controller.
// The master side (clock core) drives the time/compare events and the
// user button levels, and it receives the buzzer, LED and snooze status.
// The slave side is the ring controller.
interface alarm_ring_if;

    // Events and levels from the clock core and the front panel
    logic       enable;       // alarm armed switch level
    logic       alarm_match;  // current time == alarm time (level)
    logic       minute_tick;  // one-cycle pulse per minute
    logic       snooze_btn;   // debounced level, rising edge = press
    logic       stop_btn;     // debounced level, rising edge = press

    // Status back to the panel and the buzzer driver
    logic       ring;         // buzzer drive
    logic       led_ring;     // blinking alarm LED
    logic       snoozing;     // snooze in progress
    logic [3:0] snooze_left;  // minutes left in the current snooze
    logic [3:0] snooze_used;  // snoozes consumed in this session

    modport master (
        output enable,
        output alarm_match,
        output minute_tick,
        output snooze_btn,
        output stop_btn,
        input  ring,
        input  led_ring,
        input  snoozing,
        input  snooze_left,
        input  snooze_used
    );

    modport slave (
        input  enable,
        input  alarm_match,
        input  minute_tick,
        input  snooze_btn,
        input  stop_btn,
        output ring,
        output led_ring,
        output snoozing,
        output snooze_left,
        output snooze_used
    );

endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller.
// Turns the "time equals alarm time" level into a ringing session with
// snooze, stop, an unanswered-ring timeout and a blinking alarm LED.
// Every output is a flop loaded from the next-state decode, so outputs
// change on the clock edge that samples the causing input edge.
// Parameter ranges: SNOOZE_MIN 1..15, RING_TIMEOUT_MIN >= 1,
// MAX_SNOOZE 1..15, BLINK_ON < BLINK_PERIOD.
module alarm_ring_ctrl #(
    parameter int SNOOZE_MIN       = 9,
    parameter int RING_TIMEOUT_MIN = 5,
    parameter int MAX_SNOOZE       = 3,
    parameter int BLINK_PERIOD     = 50_000_000,
    parameter int BLINK_ON         = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,   // synchronous, active-low
    alarm_ring_if.slave        bus
);

    // A timeout of one minute still needs a one-bit counter to exist.
    localparam int RM_W = (RING_TIMEOUT_MIN > 1) ? $clog2(RING_TIMEOUT_MIN) : 1;
    localparam int BL_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    localparam logic [RM_W-1:0] RM_LAST  = RM_W'(RING_TIMEOUT_MIN - 1);
    localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_PERIOD - 1);
    localparam logic [BL_W-1:0] BL_ON    = BL_W'(BLINK_ON);
    localparam logic [3:0]      SNZ_LOAD = 4'(SNOOZE_MIN);
    localparam logic [3:0]      SNZ_MAX  = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t          state_q,       state_d;
    logic [RM_W-1:0] ring_min_q,    ring_min_d;
    logic [BL_W-1:0] blink_q,       blink_d;
    logic [3:0]      snooze_left_q, snooze_left_d;
    logic [3:0]      snooze_used_q, snooze_used_d;

    // Input history for rising-edge detection; reset to 1 so a level that
    // is already high when reset releases does not count as a press.
    logic match_hist_q, match_hist_d;
    logic snz_hist_q,   snz_hist_d;
    logic stop_hist_q,  stop_hist_d;

    // Registered outputs
    logic ring_q,     ring_d;
    logic led_ring_q, led_ring_d;
    logic snoozing_q, snoozing_d;

    logic match_edge;
    logic snz_edge;
    logic stop_edge;

    // Free-running blink phase, wrapping at the end of the period.
    function automatic logic [BL_W-1:0] blink_next(input logic [BL_W-1:0] cur);
        if (cur == BL_LAST) begin
            return '0;
        end
        return cur + BL_W'(1);
    endfunction

    // Rising edges relative to last cycle's input levels.
    always_comb begin
        match_edge = bus.alarm_match & ~match_hist_q;
        snz_edge   = bus.snooze_btn  & ~snz_hist_q;
        stop_edge  = bus.stop_btn    & ~stop_hist_q;
    end

    // Next-state decode: session control, counters and output values.
    always_comb begin
        state_d       = state_q;
        ring_min_d    = ring_min_q;
        snooze_left_d = snooze_left_q;
        snooze_used_d = snooze_used_q;
        blink_d       = blink_next(blink_q);

        match_hist_d  = bus.alarm_match;
        snz_hist_d    = bus.snooze_btn;
        stop_hist_d   = bus.stop_btn;

        unique case (state_q)
            ST_IDLE: begin
                // Only a fresh match edge starts a session; buttons and
                // ticks have no meaning while idle.
                if (bus.enable && match_edge) begin
                    state_d       = ST_RINGING;
                    ring_min_d    = '0;
                    snooze_used_d = '0;
                    blink_d       = '0;
                end
            end

            ST_RINGING: begin
                if (!bus.enable || stop_edge) begin
                    state_d       = ST_IDLE;
                    snooze_left_d = '0;
                end else if (snz_edge && (snooze_used_q < SNZ_MAX)) begin
                    // A tick arriving together with the snooze press is
                    // dropped: the snooze period starts full.
                    state_d       = ST_SNOOZE;
                    snooze_left_d = SNZ_LOAD;
                    snooze_used_d = snooze_used_q + 4'd1;
                end else if (bus.minute_tick) begin
                    if (ring_min_q == RM_LAST) begin
                        state_d       = ST_IDLE;
                        snooze_left_d = '0;
                    end else begin
                        ring_min_d = ring_min_q + RM_W'(1);
                    end
                end
            end

            ST_SNOOZE: begin
                if (!bus.enable || stop_edge) begin
                    state_d       = ST_IDLE;
                    snooze_left_d = '0;
                end else if (bus.minute_tick) begin
                    if (snooze_left_q == 4'd1) begin
                        state_d       = ST_RINGING;
                        ring_min_d    = '0;
                        blink_d       = '0;
                        snooze_left_d = '0;
                    end else begin
                        snooze_left_d = snooze_left_q - 4'd1;
                    end
                end
            end

            default: begin
                state_d       = ST_IDLE;
                snooze_left_d = '0;
            end
        endcase

        // The blink phase only advances while ringing, so every ringing
        // period begins with the LED on.
        if (state_d != ST_RINGING) begin
            blink_d = '0;
        end

        ring_d     = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZE);
        led_ring_d = ring_d && (blink_d < BL_ON);
    end

    // State, counters, edge history and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ring_min_q    <= '0;
            blink_q       <= '0;
            snooze_left_q <= '0;
            snooze_used_q <= '0;
            match_hist_q  <= 1'b1;
            snz_hist_q    <= 1'b1;
            stop_hist_q   <= 1'b1;
            ring_q        <= 1'b0;
            led_ring_q    <= 1'b0;
            snoozing_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_min_q    <= ring_min_d;
            blink_q       <= blink_d;
            snooze_left_q <= snooze_left_d;
            snooze_used_q <= snooze_used_d;
            match_hist_q  <= match_hist_d;
            snz_hist_q    <= snz_hist_d;
            stop_hist_q   <= stop_hist_d;
            ring_q        <= ring_d;
            led_ring_q    <= led_ring_d;
            snoozing_q    <= snoozing_d;
        end
    end

    assign bus.ring        = ring_q;
    assign bus.led_ring    = led_ring_q;
    assign bus.snoozing    = snoozing_q;
    assign bus.snooze_left = snooze_left_q;
    assign bus.snooze_used = snooze_used_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Testbench for alarm_ring_ctrl with small parameters. Stimulus drives the
// inputs on the falling edge and queues the output values expected after
// the next rising edge; a monitor process pops and checks them on the
// following falling edge.
module tb_alarm_ring_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alarm_ring_if bus ();

    alarm_ring_ctrl #(
        .SNOOZE_MIN       (2),
        .RING_TIMEOUT_MIN (3),
        .MAX_SNOOZE       (2),
        .BLINK_PERIOD     (10),
        .BLINK_ON         (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        int         due;
        logic       ring;
        logic       led;
        logic       snz;
        logic [3:0] left;
        logic [3:0] used;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue the outputs expected after the coming rising edge, then let
    // that edge pass; one-cycle tick pulses are cleared afterwards.
    task automatic step_exp(input string name, input logic r, input logic l,
                            input logic s, input logic [3:0] lf, input logic [3:0] u);
        exp_t e;
        e.name = name;
        e.due  = cyc + 1;
        e.ring = r;
        e.led  = l;
        e.snz  = s;
        e.left = lf;
        e.used = u;
        sb.push_back(e);
        @(negedge clk);
        bus.minute_tick = 1'b0;
    endtask

    // Monitor: compare every queued expectation that has fallen due.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.due < cyc) begin
                    n_bad++;
                    $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
                end else if ({bus.ring, bus.led_ring, bus.snoozing, bus.snooze_left, bus.snooze_used}
                             !== {e.ring, e.led, e.snz, e.left, e.used}) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got ring=%b led=%b snz=%b left=%0d used=%0d, want ring=%b led=%b snz=%b left=%0d used=%0d",
                             e.name, cyc, bus.ring, bus.led_ring, bus.snoozing, bus.snooze_left,
                             bus.snooze_used, e.ring, e.led, e.snz, e.left, e.used);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst             = 1'b0;
        bus.enable      = 1'b0;
        bus.alarm_match = 1'b1;
        bus.minute_tick = 1'b0;
        bus.snooze_btn  = 1'b0;
        bus.stop_btn    = 1'b0;

        // Reset held two cycles with the match level already high
        step_exp("reset0", 0, 0, 0, 4'd0, 4'd0);
        step_exp("reset1", 0, 0, 0, 4'd0, 4'd0);
        rst        = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) step_exp("no_edge_at_release", 0, 0, 0, 4'd0, 4'd0);

        // Fresh match edge: ring with blink 3 on / 7 off
        bus.alarm_match = 1'b0;
        step_exp("match_low", 0, 0, 0, 4'd0, 4'd0);
        bus.alarm_match = 1'b1;
        for (int k = 0; k < 12; k++) step_exp("blink", 1, ((k % 10) < 3), 0, 4'd0, 4'd0);

        // Unanswered timeout after three ticks (blink phase 12, 13)
        bus.minute_tick = 1'b1; step_exp("ring_tick1", 1, 1, 0, 4'd0, 4'd0);
        bus.minute_tick = 1'b1; step_exp("ring_tick2", 1, 0, 0, 4'd0, 4'd0);
        bus.minute_tick = 1'b1; step_exp("timeout", 0, 0, 0, 4'd0, 4'd0);
        for (int i = 0; i < 20; i++) step_exp("no_retrigger", 0, 0, 0, 4'd0, 4'd0);

        // Snooze sequence up to the snooze limit
        bus.alarm_match = 1'b0; step_exp("s4_idle", 0, 0, 0, 4'd0, 4'd0);
        bus.alarm_match = 1'b1; step_exp("s4_ring", 1, 1, 0, 4'd0, 4'd0);
        bus.snooze_btn = 1'b1; bus.minute_tick = 1'b1;
        step_exp("snooze1_tick_dropped", 0, 0, 1, 4'd2, 4'd1);
        bus.snooze_btn = 1'b0; bus.minute_tick = 1'b1;
        step_exp("snooze1_left1", 0, 0, 1, 4'd1, 4'd1);
        bus.minute_tick = 1'b1; step_exp("rering1", 1, 1, 0, 4'd0, 4'd1);
        bus.snooze_btn = 1'b1; step_exp("snooze2", 0, 0, 1, 4'd2, 4'd2);
        bus.snooze_btn = 1'b0; bus.minute_tick = 1'b1;
        step_exp("snooze2_left1", 0, 0, 1, 4'd1, 4'd2);
        bus.minute_tick = 1'b1; step_exp("rering2", 1, 1, 0, 4'd0, 4'd2);
        step_exp("rering2_b1", 1, 1, 0, 4'd0, 4'd2);
        bus.snooze_btn = 1'b1; step_exp("snooze3_ignored", 1, 1, 0, 4'd0, 4'd2);
        bus.snooze_btn = 1'b0; step_exp("rering2_b3", 1, 0, 0, 4'd0, 4'd2);

        // Stop, stop+snooze together, and enable low during snooze
        bus.stop_btn = 1'b1; step_exp("stop_used_held", 0, 0, 0, 4'd0, 4'd2);
        bus.stop_btn = 1'b0; bus.alarm_match = 1'b0;
        step_exp("idle_used_held", 0, 0, 0, 4'd0, 4'd2);
        bus.alarm_match = 1'b1; step_exp("s5_ring", 1, 1, 0, 4'd0, 4'd0);
        bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1;
        step_exp("stop_beats_snooze", 0, 0, 0, 4'd0, 4'd0);
        bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0; bus.alarm_match = 1'b0;
        step_exp("s5_idle", 0, 0, 0, 4'd0, 4'd0);
        bus.alarm_match = 1'b1; step_exp("s5_ring2", 1, 1, 0, 4'd0, 4'd0);
        bus.snooze_btn = 1'b1; step_exp("s5_snooze", 0, 0, 1, 4'd2, 4'd1);
        bus.snooze_btn = 1'b0; bus.enable = 1'b0;
        step_exp("disable_in_snooze", 0, 0, 0, 4'd0, 4'd1);

        // Reset mid-ring wins over a simultaneous tick
        bus.enable = 1'b1; bus.alarm_match = 1'b0;
        step_exp("s6_idle", 0, 0, 0, 4'd0, 4'd1);
        bus.alarm_match = 1'b1; step_exp("s6_ring", 1, 1, 0, 4'd0, 4'd0);
        rst = 1'b0; bus.minute_tick = 1'b1;
        step_exp("reset_mid_ring", 0, 0, 0, 4'd0, 4'd0);
        rst = 1'b1;
        step_exp("after_reset0", 0, 0, 0, 4'd0, 4'd0);
        step_exp("after_reset1", 0, 0, 0, 4'd0, 4'd0);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
